trivium_host_if: RTL and testbench
==================================

// Module: trivium_host_if
// PURPOSE
//  Parallel-to-serial host adapter that sits directly upstream/downstream of trivium_top.
//  Accepts an 80-bit key and an 80-bit IV, plus 32-bit plaintext words, over valid/ready handshakes.
//  Generates the trivium_top serial protocol (dat/get_dat/ld_keys/end) and reassembles the
//  serial ciphertext bits into 32-bit output words. Shifting is LSB first throughout.
// PARAMETERS
//  KEY_W        80    key width, in bits
//  IV_W         80    IV width, in bits
//  WORD_W       32    data word width, in bits
//  INIT_TMO     2048  max cycles in WAIT_INIT before flagging an error
// PORTS
//  clk_i          in   1       clock
//  n_rst_i        in   1       reset, asynchronous, active-low
//  key_i          in   KEY_W   key, sampled on init handshake
//  iv_i           in   IV_W    IV, sampled on init handshake
//  init_valid_i   in   1       request a new key/IV session
//  init_ready_o   out  1       high only in IDLE
//  wd_i           in   WORD_W  plaintext word
//  wd_valid_i     in   1       plaintext word valid
//  wd_ready_o     out  1       = (st==RUN) & (!wd_valid_o | wd_ready_i) & !end_req_i
//  wd_o           out  WORD_W  ciphertext word
//  wd_valid_o     out  1       ciphertext word valid; held until wd_ready_i
//  wd_ready_i     in   1       ciphertext sink ready
//  end_req_i      in   1       close the session (level signal)
//  err_o          out  1       sticky init-timeout flag; cleared on next init handshake
//  triv_dat_o     out  1       to trivium_top dat_i
//  triv_get_o     out  1       to trivium_top get_dat_i
//  triv_ld_o      out  1       to trivium_top ld_keys_i
//  triv_end_o     out  1       to trivium_top end_i
//  triv_dat_i     in   1       from trivium_top dat_o
//  triv_ready_i   in   1       from trivium_top ready_o
// BEHAVIOUR
//  Reset: st=IDLE; all outputs 0 except init_ready_o=1; all counters and shift registers 0.
//  Reset mid-operation aborts immediately, with no end pulse.
//  Init handshake at cycle T latches the key and IV and clears err_o:
//   - SHKEY  T+1..T+80: get=1, dat=key[k].
//   - SHIV   T+81..T+160: get=1, dat=iv[k]; ld=1 only in T+160.
//   - LOAD   T+161: get=1, dat=0.
//  WAIT_INIT: get=0. Go to RUN on the cycle after triv_ready_i is sampled 1.
//   If the timeout counter reaches INIT_TMO-1: err_o<=1, go to IDLE.
//  RUN: get=0, dat=0.
//   - Word handshake at cycle W -> SHWORD W+1..W+32: get=1, dat=wd[k].
//   - triv_dat_i is sampled at the posedge ending each bit cycle into a SIPO, entering at the MSB.
//   - End of W+32: wd_o<=SIPO, wd_valid_o=1 from W+33; return to RUN.
//   - Back-to-back: the next word can be accepted in W+33 if the output slot is free or being drained.
//  Output slot: one entry. wd_valid_o falls the cycle after a (valid & ready) handshake.
//   No word is accepted while the slot is full and not draining.
//  End: in RUN with end_req_i=1 and no word in flight -> ENDP for one cycle (triv_end_o=1),
//   then IDLE. Priority: end_req_i blocks wd_ready_o, so end wins over a simultaneous word.
//   A word still pending in the output slot stays valid across ENDP/IDLE.
//  init_valid_i is ignored outside IDLE. wd_valid_i is ignored outside RUN.
//  Bit counter: $clog2(max(KEY_W,IV_W,WORD_W)) bits; wraps to 0 at the end of each phase.
//  States: IDLE, SHKEY, SHIV, LOAD, WAIT_INIT, RUN, SHWORD, ENDP.
// STRUCTURE
//  trivium_defs.vh: state encodings, default widths, INIT_TMO default (shared with the tb).
//  Sub-module trivium_bit_shifter: parameterised PISO/SIPO with load, shift, and LSB/MSB taps.
//   Instantiate it for key, IV, data-in and data-out.
//  Top level holds the FSM, bit counter, timeout counter and output slot.
// TESTING
//  Reset: hold n_rst_i=0 -> init_ready_o=1; wd_valid_o, triv_get_o, triv_ld_o, triv_end_o, err_o all 0.
//  Init: key=0x0123456789ABCDEF0123, iv=all-ones
//   -> 80 key bits LSB first, then 80 IV bits; ld=1 only on IV bit 79; LOAD cycle;
//   -> triv_ready_i at +1152 -> wd_ready_o=1 on the next cycle.
//  Word: wd_i=0x00000000 against a trivium_top model -> wd_o equals the trivium_ref_out word,
//   wd_valid_o exactly 33 cycles after the handshake.
//  Backpressure: wd_ready_i=0 for 50 cycles with 2 words pending -> the second word is not
//   accepted; no output is lost; the order is preserved.
//  Timeout: triv_ready_i held at 0 -> err_o=1 after 2048 WAIT_INIT cycles; back to IDLE;
//   cleared on the next init.
//  End/reset: end_req_i together with wd_valid_i -> one-cycle triv_end_o, no word taken;
//   n_rst_i low during SHWORD -> all outputs return to their reset values at once.

Source files
------------

// File: rtl/trivium_host_if_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : trivium_host_if_pkg
//  Description : Shared state encodings and default widths for the Trivium
//                host adapter.
//  Revision    : 1.0  initial release
// ============================================================================
package trivium_host_if_pkg;

    localparam int KEY_W_DEF    = 80;
    localparam int IV_W_DEF     = 80;
    localparam int WORD_W_DEF   = 32;
    localparam int INIT_TMO_DEF = 2048;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_SHKEY     = 3'd1,
        ST_SHIV      = 3'd2,
        ST_LOAD      = 3'd3,
        ST_WAIT_INIT = 3'd4,
        ST_RUN       = 3'd5,
        ST_SHWORD    = 3'd6,
        ST_ENDP      = 3'd7
    } state_t;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage
`default_nettype wire

// File: rtl/trivium_bit_shifter.sv
`default_nettype none
// ============================================================================
//  Module      : trivium_bit_shifter
//  Description : Parameterised right-shifting PISO/SIPO with parallel load,
//                serial input at the MSB and LSB/MSB taps.
//  Revision    : 1.0  initial release
// ============================================================================
module trivium_bit_shifter #(
    parameter int W = 32
) (
    input  logic         clk_i,
    input  logic         n_rst_i,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    input  logic         shift_i,
    input  logic         ser_i,
    output logic [W-1:0] q_o,
    output logic [W-1:0] nxt_o,
    output logic         lsb_o,
    output logic         msb_o
);
    import trivium_host_if_pkg::*;

    logic [W-1:0] r_q;
    logic [W-1:0] w_shifted;

    // nxt_o is the value the register takes after one shift
    generate
        if (W == 1) begin : g_single
            assign w_shifted = ser_i;
        end else begin : g_multi
            assign w_shifted = {ser_i, r_q[W-1:1]};
        end
    endgenerate

    always_ff @(posedge clk_i or negedge n_rst_i) begin
        if (!n_rst_i) begin
            r_q <= '0;
        end else if (load_i) begin
            r_q <= load_val_i;
        end else if (shift_i) begin
            r_q <= w_shifted;
        end
    end

    assign q_o   = r_q;
    assign nxt_o = w_shifted;
    assign lsb_o = r_q[0];
    assign msb_o = r_q[W-1];

endmodule
`default_nettype wire

// File: rtl/trivium_host_if.sv
`default_nettype none
// ============================================================================
//  Module      : trivium_host_if
//  Description : Parallel-to-serial host adapter for trivium_top: serialises
//                key/IV/plaintext LSB first and reassembles ciphertext words.
//  Revision    : 1.0  initial release
// ============================================================================
module trivium_host_if
    import trivium_host_if_pkg::*;
#(
    parameter int KEY_W    = KEY_W_DEF,
    parameter int IV_W     = IV_W_DEF,
    parameter int WORD_W   = WORD_W_DEF,
    parameter int INIT_TMO = INIT_TMO_DEF
) (
    input  logic              clk_i,
    input  logic              n_rst_i,
    input  logic [KEY_W-1:0]  key_i,
    input  logic [IV_W-1:0]   iv_i,
    input  logic              init_valid_i,
    output logic              init_ready_o,
    input  logic [WORD_W-1:0] wd_i,
    input  logic              wd_valid_i,
    output logic              wd_ready_o,
    output logic [WORD_W-1:0] wd_o,
    output logic              wd_valid_o,
    input  logic              wd_ready_i,
    input  logic              end_req_i,
    output logic              err_o,
    output logic              triv_dat_o,
    output logic              triv_get_o,
    output logic              triv_ld_o,
    output logic              triv_end_o,
    input  logic              triv_dat_i,
    input  logic              triv_ready_i
);

    localparam int c_cnt_w = $clog2(max3(KEY_W, IV_W, WORD_W));
    localparam int c_tmo_w = $clog2(INIT_TMO);

    localparam logic [c_cnt_w-1:0] c_key_last  = c_cnt_w'(KEY_W - 1);
    localparam logic [c_cnt_w-1:0] c_iv_last   = c_cnt_w'(IV_W - 1);
    localparam logic [c_cnt_w-1:0] c_word_last = c_cnt_w'(WORD_W - 1);
    localparam logic [c_tmo_w-1:0] c_tmo_last  = c_tmo_w'(INIT_TMO - 1);

    state_t              r_st;
    state_t              w_st_nxt;
    logic [c_cnt_w-1:0]  r_bit_cnt;
    logic [c_tmo_w-1:0]  r_tmo_cnt;
    logic                r_err;
    logic                r_wd_valid;
    logic [WORD_W-1:0]   r_wd;

    logic                w_init_acc;
    logic                w_wd_acc;
    logic                w_wd_rdy;
    logic                w_key_last;
    logic                w_iv_last;
    logic                w_word_last;
    logic                w_bit_phase;
    logic                w_phase_last;
    logic                w_word_done;
    logic                w_tmo_hit;

    logic                w_key_bit;
    logic                w_iv_bit;
    logic                w_din_bit;
    logic [WORD_W-1:0]   w_sipo_nxt;

    logic [KEY_W-1:0]    w_key_q;
    logic [KEY_W-1:0]    w_key_nxt;
    logic                w_key_msb;
    logic [IV_W-1:0]     w_iv_q;
    logic [IV_W-1:0]     w_iv_nxt;
    logic                w_iv_msb;
    logic [WORD_W-1:0]   w_din_q;
    logic [WORD_W-1:0]   w_din_nxt;
    logic                w_din_msb;
    logic [WORD_W-1:0]   w_sipo_q;
    logic                w_sipo_lsb;
    logic                w_sipo_msb;
    logic                w_unused_taps;

    // ------------------------------------------------------------------
    // Handshakes and phase decode
    // ------------------------------------------------------------------
    assign w_init_acc  = (r_st == ST_IDLE) && init_valid_i;
    // end_req_i blocks acceptance so a close always wins over a new word
    assign w_wd_rdy    = (r_st == ST_RUN) && (!r_wd_valid || wd_ready_i) && !end_req_i;
    assign w_wd_acc    = w_wd_rdy && wd_valid_i;

    assign w_key_last  = (r_bit_cnt == c_key_last);
    assign w_iv_last   = (r_bit_cnt == c_iv_last);
    assign w_word_last = (r_bit_cnt == c_word_last);

    assign w_bit_phase  = (r_st == ST_SHKEY) || (r_st == ST_SHIV) || (r_st == ST_SHWORD);
    assign w_phase_last = ((r_st == ST_SHKEY)  && w_key_last) ||
                          ((r_st == ST_SHIV)   && w_iv_last)  ||
                          ((r_st == ST_SHWORD) && w_word_last);
    assign w_word_done  = (r_st == ST_SHWORD) && w_word_last;

    assign w_tmo_hit   = (r_st == ST_WAIT_INIT) && !triv_ready_i && (r_tmo_cnt == c_tmo_last);

    // ------------------------------------------------------------------
    // Shift registers
    // ------------------------------------------------------------------
    trivium_bit_shifter #(.W(KEY_W)) u_key_sh (
        .clk_i      (clk_i),
        .n_rst_i    (n_rst_i),
        .load_i     (w_init_acc),
        .load_val_i (key_i),
        .shift_i    (r_st == ST_SHKEY),
        .ser_i      (1'b0),
        .q_o        (w_key_q),
        .nxt_o      (w_key_nxt),
        .lsb_o      (w_key_bit),
        .msb_o      (w_key_msb)
    );

    trivium_bit_shifter #(.W(IV_W)) u_iv_sh (
        .clk_i      (clk_i),
        .n_rst_i    (n_rst_i),
        .load_i     (w_init_acc),
        .load_val_i (iv_i),
        .shift_i    (r_st == ST_SHIV),
        .ser_i      (1'b0),
        .q_o        (w_iv_q),
        .nxt_o      (w_iv_nxt),
        .lsb_o      (w_iv_bit),
        .msb_o      (w_iv_msb)
    );

    trivium_bit_shifter #(.W(WORD_W)) u_din_sh (
        .clk_i      (clk_i),
        .n_rst_i    (n_rst_i),
        .load_i     (w_wd_acc),
        .load_val_i (wd_i),
        .shift_i    (r_st == ST_SHWORD),
        .ser_i      (1'b0),
        .q_o        (w_din_q),
        .nxt_o      (w_din_nxt),
        .lsb_o      (w_din_bit),
        .msb_o      (w_din_msb)
    );

    // Ciphertext enters at the MSB so the first bit ends up in bit 0
    trivium_bit_shifter #(.W(WORD_W)) u_dout_sh (
        .clk_i      (clk_i),
        .n_rst_i    (n_rst_i),
        .load_i     (1'b0),
        .load_val_i ('0),
        .shift_i    (r_st == ST_SHWORD),
        .ser_i      (triv_dat_i),
        .q_o        (w_sipo_q),
        .nxt_o      (w_sipo_nxt),
        .lsb_o      (w_sipo_lsb),
        .msb_o      (w_sipo_msb)
    );

    assign w_unused_taps = ^{w_key_q, w_key_nxt, w_key_msb, w_iv_q, w_iv_nxt, w_iv_msb,
                             w_din_q, w_din_nxt, w_din_msb, w_sipo_q, w_sipo_lsb, w_sipo_msb};

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge n_rst_i) begin
        if (!n_rst_i) begin
            r_st <= ST_IDLE;
        end else begin
            r_st <= w_st_nxt;
        end
    end

    always_comb begin
        w_st_nxt   = r_st;
        triv_get_o = 1'b0;
        triv_dat_o = 1'b0;
        triv_ld_o  = 1'b0;
        triv_end_o = 1'b0;
        case (r_st)
            ST_IDLE: begin
                if (init_valid_i) w_st_nxt = ST_SHKEY;
            end
            ST_SHKEY: begin
                triv_get_o = 1'b1;
                triv_dat_o = w_key_bit;
                if (w_key_last) w_st_nxt = ST_SHIV;
            end
            ST_SHIV: begin
                triv_get_o = 1'b1;
                triv_dat_o = w_iv_bit;
                if (w_iv_last) begin
                    triv_ld_o = 1'b1;
                    w_st_nxt  = ST_LOAD;
                end
            end
            ST_LOAD: begin
                triv_get_o = 1'b1;
                w_st_nxt   = ST_WAIT_INIT;
            end
            ST_WAIT_INIT: begin
                if (triv_ready_i)   w_st_nxt = ST_RUN;
                else if (w_tmo_hit) w_st_nxt = ST_IDLE;
            end
            ST_RUN: begin
                if (w_wd_acc)       w_st_nxt = ST_SHWORD;
                else if (end_req_i) w_st_nxt = ST_ENDP;
            end
            ST_SHWORD: begin
                triv_get_o = 1'b1;
                triv_dat_o = w_din_bit;
                if (w_word_last) w_st_nxt = ST_RUN;
            end
            ST_ENDP: begin
                triv_end_o = 1'b1;
                w_st_nxt   = ST_IDLE;
            end
            default: w_st_nxt = ST_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Bit counter, timeout counter, error flag
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge n_rst_i) begin
        if (!n_rst_i) begin
            r_bit_cnt <= '0;
        end else if (w_bit_phase) begin
            r_bit_cnt <= w_phase_last ? '0 : r_bit_cnt + c_cnt_w'(1);
        end
    end

    always_ff @(posedge clk_i or negedge n_rst_i) begin
        if (!n_rst_i) begin
            r_tmo_cnt <= '0;
        end else if (r_st == ST_WAIT_INIT) begin
            r_tmo_cnt <= r_tmo_cnt + c_tmo_w'(1);
        end else begin
            r_tmo_cnt <= '0;
        end
    end

    always_ff @(posedge clk_i or negedge n_rst_i) begin
        if (!n_rst_i) begin
            r_err <= 1'b0;
        end else if (w_init_acc) begin
            r_err <= 1'b0;
        end else if (w_tmo_hit) begin
            r_err <= 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Single-entry output slot; survives ENDP/IDLE until drained
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge n_rst_i) begin
        if (!n_rst_i) begin
            r_wd       <= '0;
            r_wd_valid <= 1'b0;
        end else if (w_word_done) begin
            r_wd       <= w_sipo_nxt;
            r_wd_valid <= 1'b1;
        end else if (r_wd_valid && wd_ready_i) begin
            r_wd_valid <= 1'b0;
        end
    end

    assign init_ready_o = (r_st == ST_IDLE);
    assign wd_ready_o   = w_wd_rdy;
    assign wd_o         = r_wd;
    assign wd_valid_o   = r_wd_valid;
    assign err_o        = r_err;

endmodule
`default_nettype wire

// File: tb/tb_trivium_host_if.sv
`default_nettype none
// ============================================================================
//  Module      : tb_trivium_host_if
//  Description : Directed bench for trivium_host_if with a behavioural
//                trivium_top model on the serial side.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_trivium_host_if;

    logic         clk_i        = 1'b0;
    logic         n_rst_i      = 1'b0;
    logic [79:0]  key_i        = '0;
    logic [79:0]  iv_i         = '0;
    logic         init_valid_i = 1'b0;
    logic         init_ready_o;
    logic [31:0]  wd_i         = '0;
    logic         wd_valid_i   = 1'b0;
    logic         wd_ready_o;
    logic [31:0]  wd_o;
    logic         wd_valid_o;
    logic         wd_ready_i   = 1'b1;
    logic         end_req_i    = 1'b0;
    logic         err_o;
    logic         triv_dat_o;
    logic         triv_get_o;
    logic         triv_ld_o;
    logic         triv_end_o;
    logic         triv_dat_i;
    logic         triv_ready_i;

    int n_cmp = 0;
    int n_bad = 0;

    trivium_host_if dut (
        .clk_i        (clk_i),
        .n_rst_i      (n_rst_i),
        .key_i        (key_i),
        .iv_i         (iv_i),
        .init_valid_i (init_valid_i),
        .init_ready_o (init_ready_o),
        .wd_i         (wd_i),
        .wd_valid_i   (wd_valid_i),
        .wd_ready_o   (wd_ready_o),
        .wd_o         (wd_o),
        .wd_valid_o   (wd_valid_o),
        .wd_ready_i   (wd_ready_i),
        .end_req_i    (end_req_i),
        .err_o        (err_o),
        .triv_dat_o   (triv_dat_o),
        .triv_get_o   (triv_get_o),
        .triv_ld_o    (triv_ld_o),
        .triv_end_o   (triv_end_o),
        .triv_dat_i   (triv_dat_i),
        .triv_ready_i (triv_ready_i)
    );

    always #5 clk_i = ~clk_i;

    // ---------------- Trivium reference ----------------
    function automatic logic triv_z(input logic [288:1] s);
        return s[66] ^ s[93] ^ s[162] ^ s[177] ^ s[243] ^ s[288];
    endfunction

    function automatic logic [288:1] triv_step(input logic [288:1] s);
        logic t1, t2, t3;
        logic [288:1] n;
        t1 = s[66]  ^ s[93]  ^ (s[91]  & s[92])  ^ s[171];
        t2 = s[162] ^ s[177] ^ (s[175] & s[176]) ^ s[264];
        t3 = s[243] ^ s[288] ^ (s[286] & s[287]) ^ s[69];
        n = s;
        n[93:1]    = {s[92:1], t3};
        n[177:94]  = {s[176:94], t1};
        n[288:178] = {s[287:178], t2};
        return n;
    endfunction

    function automatic logic [288:1] triv_load(input logic [79:0] k, input logic [79:0] v);
        logic [288:1] s;
        s = '0;
        s[80:1]    = k;
        s[173:94]  = v;
        s[288:286] = 3'b111;
        for (int i = 0; i < 1152; i++) s = triv_step(s);
        return s;
    endfunction

    // ---------------- trivium_top behavioural model ----------------
    logic [79:0]  m_key, m_iv;
    logic [7:0]   m_cnt;
    int           m_warm;
    logic         m_rdy;
    logic         m_clr    = 1'b0;
    logic         hold_rdy = 1'b0;
    logic [288:1] m_s;

    always @(posedge clk_i or negedge n_rst_i) begin
        if (!n_rst_i) begin
            m_key <= '0; m_iv <= '0; m_cnt <= '0; m_warm <= 0; m_rdy <= 1'b0; m_s <= '0;
        end else if (m_clr || triv_end_o) begin
            m_cnt <= '0; m_warm <= 0; m_rdy <= 1'b0;
        end else if (m_rdy) begin
            if (triv_get_o) m_s <= triv_step(m_s);
        end else if (m_warm != 0) begin
            if (m_warm == 1151) m_rdy <= 1'b1;
            m_warm <= m_warm + 1;
        end else if (triv_get_o && m_cnt < 8'd160) begin
            if (m_cnt < 8'd80) m_key[m_cnt[6:0]] <= triv_dat_o;
            else               m_iv[7'(m_cnt - 8'd80)] <= triv_dat_o;
            m_cnt <= m_cnt + 8'd1;
            if (triv_ld_o) begin
                m_s    <= triv_load(m_key, {triv_dat_o, m_iv[78:0]});
                m_warm <= 1;
            end
        end
    end

    assign triv_dat_i   = (m_rdy && triv_get_o) ? (triv_dat_o ^ triv_z(m_s)) : 1'b0;
    assign triv_ready_i = m_rdy && !hold_rdy;

    // ---------------- expected-value bookkeeping ----------------
    logic [288:1] ref_s;
    logic [31:0]  exp_q[$];

    task automatic check_eq(input string tag, input logic [95:0] got, input logic [95:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk_i);
        #1;
    endtask

    task automatic push_exp(input logic [31:0] pt);
        logic [31:0] c;
        for (int k = 0; k < 32; k++) begin
            c[5'(k)] = pt[5'(k)] ^ triv_z(ref_s);
            ref_s    = triv_step(ref_s);
        end
        exp_q.push_back(c);
    endtask

    task automatic pop_exp(output logic [31:0] e);
        if (exp_q.size() == 0) e = 32'hxxxxxxxx;
        else                   e = exp_q.pop_front();
    endtask

    // Ends at the first RUN cycle (or at LOAD+1 when expect_ready is clear)
    task automatic do_init(input logic [79:0] k, input logic [79:0] v, input bit expect_ready);
        logic [79:0] ok, ov;
        int gets, lds, ldpos, n;
        logic loaddat;
        gets = 0; lds = 0; ldpos = -1; loaddat = 1'b0; ok = '0; ov = '0;
        ref_s = triv_load(k, v);
        cyc(); m_clr = 1'b1;
        cyc(); m_clr = 1'b0;
        key_i = k; iv_i = v; init_valid_i = 1'b1;
        #2;
        check_eq("init_ready_idle", init_ready_o, 1'b1);
        cyc(); init_valid_i = 1'b0; key_i = '0; iv_i = '0;
        for (int i = 0; i <= 160; i++) begin
            if (i > 0) cyc();
            #2;
            if (i == 0) check_eq("err_cleared", err_o, 1'b0);
            if (triv_get_o) gets++;
            if (triv_ld_o) begin lds++; ldpos = i; end
            if (i < 80)       ok[7'(i)] = triv_dat_o;
            else if (i < 160) ov[7'(i - 80)] = triv_dat_o;
            else              loaddat = triv_dat_o;
        end
        check_eq("key_stream", ok, k);
        check_eq("iv_stream", ov, v);
        check_eq("get_cycles", gets, 161);
        check_eq("ld_count", lds, 1);
        check_eq("ld_pos", ldpos, 159);
        check_eq("load_dat", loaddat, 1'b0);
        cyc(); #2;
        check_eq("wait_get", {triv_get_o, init_ready_o}, 2'b00);
        if (expect_ready) begin
            n = 0;
            while (!triv_ready_i && n < 3000) begin cyc(); #2; n++; end
            check_eq("ready_seen", triv_ready_i, 1'b1);
            check_eq("wd_ready_wait", wd_ready_o, 1'b0);
            cyc(); #2;
            check_eq("wd_ready_run", wd_ready_o, 1'b1);
        end
    endtask

    task automatic send_word(input logic [31:0] pt);
        cyc();
        wd_i = pt; wd_valid_i = 1'b1;
        #2;
        check_eq("word_accept", wd_ready_o, 1'b1);
        push_exp(pt);
        cyc(); wd_valid_i = 1'b0;
    endtask

    task automatic wait_valid(output int d);
        d = 1;
        #2;
        while (!wd_valid_o && d < 100) begin cyc(); #2; d++; end
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int d, acc;
        logic [31:0] e;

        cyc(); cyc(); #2;
        check_eq("rst_init_ready", init_ready_o, 1'b1);
        check_eq("rst_outs", {wd_valid_o, triv_get_o, triv_ld_o, triv_end_o, err_o, wd_ready_o}, 6'b0);
        cyc(); n_rst_i = 1'b1;

        do_init(80'h0123456789ABCDEF0123, {80{1'b1}}, 1'b1);

        // single word, zero plaintext
        send_word(32'h00000000);
        wait_valid(d);
        check_eq("lat_w0", d, 33);
        pop_exp(e);
        check_eq("wd_w0", wd_o, e);
        cyc(); #2;
        check_eq("drain_w0", wd_valid_o, 1'b0);

        // back-to-back: next word accepted while the slot drains
        send_word(32'hA5A53C3C);
        wait_valid(d);
        check_eq("lat_w1", d, 33);
        pop_exp(e);
        check_eq("wd_w1", wd_o, e);
        wd_i = 32'h5A5AC3C3; wd_valid_i = 1'b1;
        #1;
        check_eq("b2b_accept", wd_ready_o, 1'b1);
        push_exp(32'h5A5AC3C3);
        cyc(); wd_valid_i = 1'b0;
        wait_valid(d);
        check_eq("lat_w2", d, 33);
        pop_exp(e);
        check_eq("wd_w2", wd_o, e);

        // backpressure with a second word waiting
        cyc(); wd_ready_i = 1'b0;
        send_word(32'hDEADBEEF);
        wd_i = 32'h0BADF00D; wd_valid_i = 1'b1;
        wait_valid(d);
        check_eq("lat_bp_a", d, 33);
        acc = 0;
        for (int i = 0; i < 50; i++) begin
            cyc(); #2;
            if (wd_ready_o) acc++;
        end
        check_eq("bp_blocked", acc, 0);
        check_eq("bp_held", wd_valid_o, 1'b1);
        pop_exp(e);
        check_eq("wd_bp_a", wd_o, e);
        cyc(); wd_ready_i = 1'b1;
        #2;
        check_eq("bp_accept_b", wd_ready_o, 1'b1);
        push_exp(32'h0BADF00D);
        cyc(); wd_valid_i = 1'b0;
        wait_valid(d);
        check_eq("lat_bp_b", d, 33);
        pop_exp(e);
        check_eq("wd_bp_b", wd_o, e);

        // end with a word pending in the slot, and a simultaneous word request
        cyc(); wd_ready_i = 1'b0;
        send_word(32'h12345678);
        wait_valid(d);
        cyc();
        end_req_i = 1'b1; wd_valid_i = 1'b1; wd_i = 32'hFFFFFFFF;
        #2;
        check_eq("end_blocks_word", wd_ready_o, 1'b0);
        cyc(); end_req_i = 1'b0; wd_valid_i = 1'b0;
        #2;
        check_eq("end_pulse", {triv_end_o, triv_get_o}, 2'b10);
        cyc(); #2;
        check_eq("end_done", {triv_end_o, init_ready_o, wd_valid_o}, 3'b011);
        pop_exp(e);
        check_eq("wd_pending", wd_o, e);
        cyc(); wd_ready_i = 1'b1;
        cyc(); #2;
        check_eq("pending_drained", wd_valid_o, 1'b0);

        // init timeout
        hold_rdy = 1'b1;
        do_init(80'hFEDCBA9876543210FEDC, 80'h00000000000000000001, 1'b0);
        for (int i = 1; i <= 2047; i++) cyc();
        #2;
        check_eq("tmo_before", {err_o, init_ready_o}, 2'b00);
        cyc(); #2;
        check_eq("tmo_after", {err_o, init_ready_o}, 2'b11);
        hold_rdy = 1'b0;

        do_init(80'h13579BDF02468ACE1357, 80'h2468ACE013579BDF2468, 1'b1);

        // reset in the middle of a word
        send_word(32'h0F0F0F0F);
        for (int i = 0; i < 9; i++) cyc();
        cyc(); n_rst_i = 1'b0;
        #2;
        check_eq("rst_midword",
                 {init_ready_o, wd_valid_o, triv_get_o, triv_ld_o, triv_end_o, err_o, wd_ready_o, triv_dat_o},
                 8'b10000000);
        cyc(); n_rst_i = 1'b1;
        cyc();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
